// File: rtl/axis_eth_pad_trunc.sv
`default_nettype none
// ============================================================================
// Module      : axis_eth_pad_trunc
// Description : 8-bit AXI4-Stream Ethernet frame conditioner: zero-pads short
//               frames to MIN_LEN and truncates long frames at MAX_LEN.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_eth_pad_trunc #(
    parameter int MIN_LEN    = 60,
    parameter int MAX_LEN    = 1514,
    parameter int PAD_ENABLE = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic [CNT_WIDTH-1:0] status_frames,
    output logic                 status_pad,
    output logic                 status_trunc
);

    localparam int c_CNT_W = $clog2(MAX_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_MIN = c_CNT_W'(MIN_LEN);
    localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_PASS = 2'd0,
        ST_PAD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_user_q;

    logic               w_slot_free;
    logic               w_s_fire;
    logic [c_CNT_W-1:0] w_cnt_inc;

    assign w_slot_free = !m_axis_tvalid || m_axis_tready;
    assign w_cnt_inc   = r_cnt + c_CNT_W'(1);
    assign w_s_fire    = s_axis_tvalid && s_axis_tready;

    always_comb begin
        s_axis_tready = 1'b0;
        if (rst) begin
            case (r_state)
                ST_PASS: s_axis_tready = w_slot_free;
                ST_DROP: s_axis_tready = 1'b1;
                default: s_axis_tready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_PASS;
            r_cnt         <= '0;
            r_user_q      <= 1'b0;
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            status_frames <= '0;
            status_pad    <= 1'b0;
            status_trunc  <= 1'b0;
        end else begin
            status_pad   <= 1'b0;
            status_trunc <= 1'b0;

            if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
                status_frames <= status_frames + CNT_WIDTH'(1);

            // Drained slot goes empty unless a new byte is loaded below.
            if (m_axis_tvalid && m_axis_tready)
                m_axis_tvalid <= 1'b0;

            case (r_state)
                ST_PASS: begin
                    if (w_s_fire) begin
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tvalid <= 1'b1;
                        if (s_axis_tlast) begin
                            if (PAD_ENABLE == 0 || w_cnt_inc >= c_MIN) begin
                                m_axis_tlast <= 1'b1;
                                m_axis_tuser <= s_axis_tuser;
                                r_cnt        <= '0;
                            end else begin
                                m_axis_tlast <= 1'b0;
                                m_axis_tuser <= 1'b0;
                                r_user_q     <= s_axis_tuser;
                                r_cnt        <= w_cnt_inc;
                                r_state      <= ST_PAD;
                            end
                        end else if (w_cnt_inc == c_MAX) begin
                            m_axis_tlast <= 1'b1;
                            m_axis_tuser <= 1'b1;
                            status_trunc <= 1'b1;
                            r_cnt        <= '0;
                            r_state      <= ST_DROP;
                        end else begin
                            m_axis_tlast <= 1'b0;
                            m_axis_tuser <= 1'b0;
                            r_cnt        <= w_cnt_inc;
                        end
                    end
                end

                ST_PAD: begin
                    if (w_slot_free) begin
                        m_axis_tdata  <= 8'h00;
                        m_axis_tvalid <= 1'b1;
                        if (w_cnt_inc == c_MIN) begin
                            m_axis_tlast <= 1'b1;
                            m_axis_tuser <= r_user_q;
                            status_pad   <= 1'b1;
                            r_cnt        <= '0;
                            r_state      <= ST_PASS;
                        end else begin
                            m_axis_tlast <= 1'b0;
                            m_axis_tuser <= 1'b0;
                            r_cnt        <= w_cnt_inc;
                        end
                    end
                end

                ST_DROP: begin
                    if (w_s_fire && s_axis_tlast)
                        r_state <= ST_PASS;
                end

                default: r_state <= ST_PASS;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_eth_pad_trunc.sv
`default_nettype none
// Self-checking bench for axis_eth_pad_trunc: frame-level reference model
// feeding an expected-beat queue, compared against every output handshake.
module tb_axis_eth_pad_trunc;

    localparam int MIN_L = 60;
    localparam int MAX_L = 1514;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        m_tuser;
    logic [15:0] frames;
    logic        st_pad;
    logic        st_trunc;

    always #5 clk = ~clk;

    axis_eth_pad_trunc #(
        .MIN_LEN(MIN_L), .MAX_LEN(MAX_L), .PAD_ENABLE(1), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .status_frames(frames), .status_pad(st_pad), .status_trunc(st_trunc)
    );

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];          // {last, user, data}
    int exp_frames = 0, exp_pad = 0, exp_trunc = 0;
    int seen_pad = 0, seen_trunc = 0;
    int frame_beats = 0, last_frame_len = 0;
    logic last_frame_user = 1'b0;
    int cyc = 0, first_hs = -1, last_hs = -1, hs_count = 0;
    bit rand_ready = 1'b0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: what the emitted frame must look like.
    task automatic model_frame(input logic [7:0] b[$], input bit user);
        int n = b.size();
        int outn;
        bit u;
        if (n > MAX_L) begin
            outn = MAX_L; u = 1'b1; exp_trunc++;
        end else if (n < MIN_L) begin
            outn = MIN_L; u = user; exp_pad++;
        end else begin
            outn = n; u = user;
        end
        for (int i = 0; i < outn; i++) begin
            logic [7:0] d;
            bit lst;
            d = (i < n) ? b[i] : 8'h00;
            lst = (i == outn - 1);
            exp_q.push_back({lst, lst ? u : 1'b0, d});
        end
        exp_frames++;
    endtask

    // Output monitor / scoreboard
    initial begin
        logic [9:0] e;
        logic [9:0] held = '0;
        bit held_valid = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (st_pad) seen_pad++;
                if (st_trunc) seen_trunc++;
                if (held_valid) begin
                    chk(m_tvalid == 1'b1, "hold_valid", int'(m_tvalid), 1);
                    chk({m_tlast, m_tuser, m_tdata} == held, "hold_data",
                        int'({m_tlast, m_tuser, m_tdata}), int'(held));
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_beat", int'(m_tdata), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk(m_tdata == e[7:0], "data", int'(m_tdata), int'(e[7:0]));
                        chk(m_tlast == e[9], "tlast", int'(m_tlast), int'(e[9]));
                        if (e[9]) chk(m_tuser == e[8], "tuser", int'(m_tuser), int'(e[8]));
                    end
                    frame_beats++;
                    hs_count++;
                    last_hs = cyc;
                    if (first_hs < 0) first_hs = cyc;
                    if (m_tlast) begin
                        last_frame_len = frame_beats;
                        last_frame_user = m_tuser;
                        frame_beats = 0;
                    end
                end
                held_valid = m_tvalid && !m_tready;
                held = {m_tlast, m_tuser, m_tdata};
            end else begin
                held_valid = 1'b0;
                frame_beats = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [7:0] d, input bit last, input bit user);
        int t = 0;
        bit hs;
        s_tdata = d; s_tlast = last; s_tuser = user; s_tvalid = 1'b1;
        do begin
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            t++;
        end while (!hs && t < 200);
        if (!hs) chk(1'b0, "send_timeout", t, 200);
    endtask

    task automatic send_frame(input int len, input logic [7:0] base, input bit user,
                              input bit chk_lat);
        logic [7:0] b[$];
        for (int i = 0; i < len; i++) b.push_back(8'(base + 8'(i)));
        model_frame(b, user);
        for (int i = 0; i < len; i++) begin
            send_beat(b[i], i == len - 1, user);
            if (chk_lat && i == 0)
                chk(m_tvalid && m_tdata == b[0], "latency", int'(m_tvalid), 1);
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk); #1; t++;
        end
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        int lows;
        // Reset state
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk(m_tvalid == 1'b0, "rst_m_tvalid", int'(m_tvalid), 0);
        chk({m_tdata, m_tlast, m_tuser} == 10'h0, "rst_m_out",
            int'({m_tdata, m_tlast, m_tuser}), 0);
        chk(s_tready == 1'b0, "rst_s_tready", int'(s_tready), 0);
        chk(frames == 16'd0 && !st_pad && !st_trunc, "rst_status", int'(frames), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // 100-byte frame passes unchanged
        send_frame(100, 8'h00, 1'b0, 1'b1);
        wait_drain();
        chk(last_frame_len == 100, "t1_len", last_frame_len, 100);
        chk(last_frame_user == 1'b0, "t1_user", int'(last_frame_user), 0);
        chk(int'(frames) == 1, "t1_frames", int'(frames), 1);
        chk(seen_pad == 0 && seen_trunc == 0, "t1_pulses", seen_pad + seen_trunc, 0);

        // 10-byte frame padded to 60, tuser carried to the last beat
        send_frame(10, 8'hA0, 1'b1, 1'b0);
        lows = 0;
        repeat (50) begin @(negedge clk); if (!s_tready) lows++; end
        chk(lows == 50, "t2_tready_low", lows, 50);
        @(negedge clk);
        chk(s_tready == 1'b1, "t2_tready_back", int'(s_tready), 1);
        wait_drain();
        chk(last_frame_len == 60, "t2_len", last_frame_len, 60);
        chk(last_frame_user == 1'b1, "t2_user", int'(last_frame_user), 1);
        chk(seen_pad == 1, "t2_pad_pulse", seen_pad, 1);
        chk(int'(frames) == exp_frames, "t2_frames", int'(frames), exp_frames);

        // 1600-byte frame truncated, then a normal frame
        send_frame(1600, 8'h00, 1'b0, 1'b0);
        wait_drain();
        chk(last_frame_len == 1514, "t3_len", last_frame_len, 1514);
        chk(last_frame_user == 1'b1, "t3_user", int'(last_frame_user), 1);
        chk(seen_trunc == 1, "t3_trunc_pulse", seen_trunc, 1);
        send_frame(64, 8'h40, 1'b0, 1'b0);
        wait_drain();
        chk(last_frame_len == 64, "t3_next_len", last_frame_len, 64);

        // Exactly MAX_LEN with tlast: normal end
        send_frame(1514, 8'h11, 1'b0, 1'b0);
        wait_drain();
        chk(last_frame_len == 1514 && last_frame_user == 1'b0, "t3_max_exact",
            int'(last_frame_user), 0);
        chk(seen_trunc == exp_trunc, "t3_trunc_total", seen_trunc, exp_trunc);

        // Back-to-back 60 + 61 with no bubbles
        first_hs = -1; hs_count = 0;
        send_frame(60, 8'h20, 1'b0, 1'b0);
        send_frame(61, 8'h80, 1'b1, 1'b0);
        wait_drain();
        chk(hs_count == 121, "t4_beats", hs_count, 121);
        chk(last_hs - first_hs + 1 == 121, "t4_no_gaps", last_hs - first_hs + 1, 121);
        chk(seen_pad == 1, "t4_no_pad", seen_pad, 1);
        chk(int'(frames) == exp_frames, "t4_frames", int'(frames), exp_frames);

        // 5-byte frame under random backpressure
        rand_ready = 1'b1;
        hs_count = 0;
        send_frame(5, 8'h05, 1'b0, 1'b0);
        wait_drain();
        rand_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk(hs_count == 60, "t5_beats", hs_count, 60);
        chk(seen_pad == exp_pad, "t5_pad_total", seen_pad, exp_pad);

        // Reset during padding, then a clean 64-byte frame
        send_frame(10, 8'hC0, 1'b0, 1'b0);
        begin
            int t = 0;
            while (frame_beats < 29 && t < 200) begin @(posedge clk); #1; t++; end
            chk(frame_beats >= 29, "t6_reach_pad", frame_beats, 29);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        exp_frames = 0;
        exp_pad--;
        @(negedge clk);
        chk(m_tvalid == 1'b0, "t6_valid_cleared", int'(m_tvalid), 0);
        chk(int'(frames) == 0, "t6_frames_cleared", int'(frames), 0);
        @(posedge clk); #1;
        send_frame(64, 8'h55, 1'b1, 1'b0);
        wait_drain();
        chk(last_frame_len == 64, "t6_len", last_frame_len, 64);
        chk(last_frame_user == 1'b1, "t6_user", int'(last_frame_user), 1);
        chk(int'(frames) == 1, "t6_frames", int'(frames), 1);
        chk(seen_pad == exp_pad, "t6_pad_total", seen_pad, exp_pad);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
